// File: rtl/parking_gate_ctrl_if.sv
// Request/status bundle between the parking gate controller and its loops, beam and barrier.
interface parking_gate_ctrl_if #(
  parameter int CNT_W = 3
);
  logic             i_reqIn;
  logic             i_reqOut;
  logic             i_passSensor;
  logic             o_gateOpen;
  logic             o_dirIn;
  logic             o_carIn;
  logic             o_carOut;
  logic [CNT_W-1:0] o_occupancy;
  logic             o_full;
  logic             o_empty;
  logic             o_busy;

  modport master (
    output i_reqIn, i_reqOut, i_passSensor,
    input  o_gateOpen, o_dirIn, o_carIn, o_carOut, o_occupancy, o_full, o_empty, o_busy
  );

  modport slave (
    input  i_reqIn, i_reqOut, i_passSensor,
    output o_gateOpen, o_dirIn, o_carIn, o_carOut, o_occupancy, o_full, o_empty, o_busy
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Single-lane barrier controller: round-robin entry/exit grant, open/pass/hold sequencing,
// saturating occupancy. Define TAILGATE_ALARM_EN to add the sticky o_alarm output.
module parking_gate_ctrl #(
  parameter int CAPACITY       = 7,
  parameter int CNT_W          = 3,
  parameter int OPEN_CYCLES    = 20,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TMR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  parking_gate_ctrl_if.slave bus
`ifdef TAILGATE_ALARM_EN
  ,
  output logic              o_alarm
`endif
);

  typedef enum logic [1:0] {IDLE, OPEN, PASS, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [CNT_W-1:0] r_occ, w_occ_nxt;
  logic             r_lastIn, w_lastIn_nxt;
  logic             r_gateOpen, w_gateOpen_nxt;
  logic             r_dirIn, w_dirIn_nxt;
  logic             r_carIn, w_carIn_nxt;
  logic             r_carOut, w_carOut_nxt;

  logic w_full, w_empty, w_eligIn, w_eligOut, w_grantIn;

  assign w_full    = (r_occ == CNT_W'(CAPACITY));
  assign w_empty   = (r_occ == '0);
  assign w_eligIn  = bus.i_reqIn & ~w_full;
  assign w_eligOut = bus.i_reqOut & ~w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_occ      <= '0;
      r_lastIn   <= 1'b0;
      r_gateOpen <= 1'b0;
      r_dirIn    <= 1'b0;
      r_carIn    <= 1'b0;
      r_carOut   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_occ      <= w_occ_nxt;
      r_lastIn   <= w_lastIn_nxt;
      r_gateOpen <= w_gateOpen_nxt;
      r_dirIn    <= w_dirIn_nxt;
      r_carIn    <= w_carIn_nxt;
      r_carOut   <= w_carOut_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tmr_nxt      = r_tmr;
    w_occ_nxt      = r_occ;
    w_lastIn_nxt   = r_lastIn;
    w_gateOpen_nxt = r_gateOpen;
    w_dirIn_nxt    = r_dirIn;
    w_carIn_nxt    = 1'b0;
    w_carOut_nxt   = 1'b0;
    w_grantIn      = 1'b0;
    case (r_state)
      IDLE: begin
        w_gateOpen_nxt = 1'b0;
        w_dirIn_nxt    = 1'b0;
        // On a tie, serve the direction that was not granted last.
        w_grantIn = w_eligIn & (~w_eligOut | ~r_lastIn);
        if (w_eligIn | w_eligOut) begin
          w_state_nxt    = OPEN;
          w_gateOpen_nxt = 1'b1;
          w_dirIn_nxt    = w_grantIn;
          w_lastIn_nxt   = w_grantIn;
          w_tmr_nxt      = '0;
        end
      end
      OPEN: begin
        if (bus.i_passSensor) begin
          w_state_nxt = PASS;
        end else if (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt    = IDLE;
          w_gateOpen_nxt = 1'b0;
          w_dirIn_nxt    = 1'b0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      PASS: begin
        if (!bus.i_passSensor) begin
          w_state_nxt = HOLD;
          w_tmr_nxt   = '0;
          if (r_dirIn) begin
            w_carIn_nxt = 1'b1;
            w_occ_nxt   = w_full ? r_occ : r_occ + CNT_W'(1);
          end else begin
            w_carOut_nxt = 1'b1;
            w_occ_nxt    = w_empty ? r_occ : r_occ - CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // A tailgater in the beam restarts the hold window without counting.
        if (bus.i_passSensor) begin
          w_tmr_nxt = '0;
        end else if (r_tmr == TMR_W'(OPEN_CYCLES - 1)) begin
          w_state_nxt    = IDLE;
          w_gateOpen_nxt = 1'b0;
          w_dirIn_nxt    = 1'b0;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_gateOpen_nxt = 1'b0;
        w_dirIn_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.o_gateOpen  = r_gateOpen;
  assign bus.o_dirIn     = r_dirIn;
  assign bus.o_carIn     = r_carIn;
  assign bus.o_carOut    = r_carOut;
  assign bus.o_occupancy = r_occ;
  assign bus.o_full      = w_full;
  assign bus.o_empty     = w_empty;
  assign bus.o_busy      = (r_state != IDLE);

`ifdef TAILGATE_ALARM_EN
  logic r_pass_q, r_alarm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pass_q <= 1'b0;
      r_alarm  <= 1'b0;
    end else begin
      r_pass_q <= bus.i_passSensor;
      if (bus.i_passSensor && !r_pass_q &&
          ((r_state == HOLD) || ((r_state == IDLE) && !r_gateOpen)))
        r_alarm <= 1'b1;
    end
  end

  assign o_alarm = r_alarm;
`endif

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Controller for a single-lane parking barrier shared by entering and exiting cars.
- Arbitrates entry and exit requests and sequences the barrier through open, pass and hold phases.
- Emits one-cycle carIn/carOut pulses that drive the car counter, and keeps its own saturating occupancy count to refuse entry when full and exit when empty.

Parameters:
CAPACITY, 7, maximum occupancy; entry refused at this value
CNT_W, 3, occupancy width; must hold CAPACITY
OPEN_CYCLES, 20, cycles the barrier stays open after the car clears the beam
TIMEOUT_CYCLES, 200, cycles to wait for the beam to break before aborting
TMR_W, 8, timer width; must hold max(OPEN_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
reqIn  input  1  level; car waiting on entry loop
reqOut  input  1  level; car waiting on exit loop
passSensor  input  1  level; car inside barrier beam
gateOpen  output  1  barrier motor command (1 = open)
dirIn  output  1  1 while serving an entry, 0 otherwise
carIn  output  1  one-cycle pulse per completed entry
carOut  output  1  one-cycle pulse per completed exit
occupancy  output  CNT_W  current car count
full  output  1  occupancy == CAPACITY
empty  output  1  occupancy == 0
busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate):
  - State is IDLE and lastGrant = out.
  - gateOpen, dirIn, carIn, carOut and busy are 0; occupancy is 0; empty is 1; full is 0.
- All outputs are registered except full, empty and busy, which decode registered state.
- States: IDLE, OPEN, PASS, HOLD.
- IDLE:
  - eligIn = reqIn & !full; eligOut = reqOut & !empty.
  - Only one eligible: grant it.
  - Both eligible: grant the direction opposite lastGrant.
  - On grant: go to OPEN, latch the direction into dirIn, update lastGrant, clear the timer.
  - Requests are sampled only in IDLE and are never queued.
- OPEN:
  - gateOpen = 1 from the first OPEN cycle, i.e. one cycle after the request is sampled.
  - passSensor = 1 → PASS.
  - Timer reaches TIMEOUT_CYCLES with no beam → IDLE. gateOpen drops, no pulse, occupancy unchanged.
- PASS:
  - gateOpen = 1; the timeout is not checked.
  - passSensor sampled 0 → HOLD.
  - On that same edge: pulse carIn (dirIn = 1) or carOut (dirIn = 0) for exactly one cycle. Occupancy increments or decrements at that edge, so the new value is visible in the pulse cycle.
- HOLD:
  - gateOpen = 1 for OPEN_CYCLES cycles, then IDLE with gateOpen = 0 and dirIn = 0.
  - passSensor re-asserting in HOLD (tailgate) restarts the HOLD timer. No additional count.
- Occupancy arithmetic:
  - Saturating at 0 and CAPACITY. It can never wrap.
  - Full/empty gating at grant time guarantees no over- or underflow.
  - A decrement while full clears full in the pulse cycle.
- Simultaneous events:
  - reqIn & reqOut: round-robin as above. The first tie after reset goes to entry.
  - Request deasserting after grant does not cancel the cycle; timeout handles the abandoned car.
- carIn and carOut are never both 1.
- Back-to-back: a pending request is granted on the first IDLE cycle after HOLD, so there is a minimum one cycle of gateOpen = 0 between cars.
- Reset mid-operation: barrier closes asynchronously, no pulse is emitted, occupancy returns to 0.

Optional Feature:
- Macro: TAILGATE_ALARM_EN.
- Defined:
  - Adds output port alarm (1 bit).
  - Set on any passSensor rising edge seen in HOLD, or in IDLE with gateOpen = 0.
  - Sticky until reset; has no effect on sequencing.
- Undefined:
  - The alarm port and its logic are absent.
  - Tailgate only restarts the HOLD timer.

Test Plan:
- Reset: assert reset 5 cycles then release → gateOpen=0, occupancy=0, empty=1, full=0, no pulses, busy=0.
- Single entry: reqIn=1 with passSensor high for 5 cycles → gateOpen=1 one cycle after sampling, carIn one pulse, occupancy 0→1, gateOpen=0 exactly 20 cycles after beam clears.
- Fill and exit:
  - 7 entries → full=1; an 8th reqIn keeps gateOpen=0 for 50 cycles, occupancy stays 7.
  - Then 8 exits → occupancy 0 after 7; the 8th reqOut is ignored and empty=1.
- Simultaneous: occupancy=3, last grant was entry, reqIn=reqOut=1 → exit served first (carOut, 3→2), then entry (carIn, 2→3); carIn and carOut never coincide.
- Timeout: reqIn pulse of 1 cycle, passSensor held 0 → gateOpen=0 after 200 cycles in OPEN, no carIn, occupancy unchanged.
- Reset in PASS: assert reset while passSensor=1 → gateOpen=0 in the same cycle, occupancy=0, no pulse; with TAILGATE_ALARM_EN, a beam break in HOLD sets alarm=1, which stays 1 until reset.
